// File: rtl/datapath_somatorio.sv
// Datapath for the summation unit: down-counter, accumulator, sticky overflow and result register.
// Optional build macro SATURATE_EN: clamp the accumulator to all-ones on carry-out instead of wrapping.
module datapath_somatorio #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 ck,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     n_in,
    input  logic                 set,
    input  logic                 dec,
    input  logic                 cac,
    input  logic                 rac,
    output logic                 zero,
    output logic                 overflow,
    output logic [ACC_WIDTH-1:0] soma
);

    logic [WIDTH-1:0]     cnt_q,  cnt_d;
    logic [ACC_WIDTH-1:0] acc_q,  acc_d;
    logic                 ovf_q,  ovf_d;
    logic [ACC_WIDTH-1:0] soma_q, soma_d;
    logic [ACC_WIDTH:0]   sum;

    // One extra bit so the carry-out of acc + cnt is directly observable.
    assign sum = {1'b0, acc_q} + {1'b0, ACC_WIDTH'(cnt_q)};

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        soma_d = soma_q;

        if (set) begin
            cnt_d = n_in;
            acc_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (cac) begin
                if (sum[ACC_WIDTH]) begin
                    ovf_d = 1'b1;
                end
`ifdef SATURATE_EN
                if (sum[ACC_WIDTH] || ovf_q) begin
                    acc_d = '1;
                end else begin
                    acc_d = sum[ACC_WIDTH-1:0];
                end
`else
                acc_d = sum[ACC_WIDTH-1:0];
`endif
            end
            // Counter parks at zero rather than wrapping to all-ones.
            if (dec && (cnt_q != '0)) begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end

        // rac samples the pre-edge accumulator, independent of set/cac.
        if (rac) begin
            soma_d = acc_q;
        end
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            soma_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
            soma_q <= soma_d;
        end
    end

    assign zero     = (cnt_q == '0);
    assign overflow = ovf_q;
    assign soma     = soma_q;

endmodule

// File: tb/tb_datapath_somatorio.sv
// Directed self-checking bench for datapath_somatorio: a 8/16 instance for the main checks and an 8/8 instance for overflow.
module tb_datapath_somatorio;

    logic        ck;
    logic        reset;
    logic [7:0]  n_in;
    logic        set, dec, cac, rac;
    logic        zero, overflow;
    logic [15:0] soma;
    logic        zero8, overflow8;
    logic [7:0]  soma8;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    datapath_somatorio #(.WIDTH(8), .ACC_WIDTH(16)) dut (
        .ck(ck), .reset(reset), .n_in(n_in),
        .set(set), .dec(dec), .cac(cac), .rac(rac),
        .zero(zero), .overflow(overflow), .soma(soma)
    );

    datapath_somatorio #(.WIDTH(8), .ACC_WIDTH(8)) dut8 (
        .ck(ck), .reset(reset), .n_in(n_in),
        .set(set), .dec(dec), .cac(cac), .rac(rac),
        .zero(zero8), .overflow(overflow8), .soma(soma8)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Apply strobes for one edge; returns 1 time unit after that edge.
    task automatic cyc(input logic s, input logic d, input logic c, input logic r, input logic [7:0] n);
        set = s; dec = d; cac = c; rac = r; n_in = n;
        @(posedge ck);
        #1;
        set = 1'b0; dec = 1'b0; cac = 1'b0; rac = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        set = 1'b0; dec = 1'b0; cac = 1'b0; rac = 1'b0; n_in = 8'd0;
        repeat (2) @(posedge ck);
        #1;
        chk_cnt++;
        if ({zero, overflow, soma} !== {1'b1, 1'b0, 16'd0})
            $display("FAIL reset_state: zero=%0b overflow=%0b soma=%0d, required zero=1 overflow=0 soma=0", zero, overflow, soma);
        else pass_cnt++;
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_sum;
        cyc(1, 0, 0, 0, 8'd5);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk_cnt++;
        if (soma !== 16'd9) $display("FAIL mid_sum_partial: soma=%0d, required 9", soma);
        else pass_cnt++;
        #2 reset = 1'b0;
        #1;
        chk_cnt++;
        if ({zero, overflow, soma} !== {1'b1, 1'b0, 16'd0})
            $display("FAIL async_reset: zero=%0b overflow=%0b soma=%0d, required zero=1 overflow=0 soma=0", zero, overflow, soma);
        else pass_cnt++;
        @(negedge ck);
        reset = 1'b1;
        #1;
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk_cnt++;
        if (soma !== 16'd0) $display("FAIL async_reset_acc: soma=%0d, required 0", soma);
        else pass_cnt++;
    endtask

    task automatic test_nominal_sum;
        cyc(1, 0, 0, 0, 8'd5);
        chk_cnt++;
        if (zero !== 1'b0) $display("FAIL nominal_after_set: zero=%0b, required 0", zero);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 1, 0, 0);
            chk_cnt++;
            if (zero !== (i == 4)) $display("FAIL nominal_zero_step%0d: zero=%0b, required %0b", i, zero, (i == 4));
            else pass_cnt++;
        end
        cyc(0, 0, 0, 1, 0);
        chk_cnt++;
        if ({soma, overflow} !== {16'd15, 1'b0})
            $display("FAIL nominal_result: soma=%0d overflow=%0b, required soma=15 overflow=0", soma, overflow);
        else pass_cnt++;
    endtask

    task automatic test_n_zero;
        cyc(1, 0, 0, 0, 8'd0);
        chk_cnt++;
        if (zero !== 1'b1) $display("FAIL n0_zero: zero=%0b, required 1", zero);
        else pass_cnt++;
        cyc(0, 0, 0, 1, 0);
        chk_cnt++;
        if (soma !== 16'd0) $display("FAIL n0_soma: soma=%0d, required 0", soma);
        else pass_cnt++;
    endtask

    task automatic test_overflow;
        logic [7:0] exp_acc2, exp_acc3;
`ifdef SATURATE_EN
        exp_acc2 = 8'd255;
        exp_acc3 = 8'd255;
`else
        exp_acc2 = 8'd253;
        exp_acc3 = 8'd250;
`endif
        cyc(1, 0, 0, 0, 8'd255);
        cyc(0, 1, 1, 0, 0);
        chk_cnt++;
        if (overflow8 !== 1'b0) $display("FAIL ovf_first_add: overflow=%0b, required 0", overflow8);
        else pass_cnt++;
        cyc(0, 1, 1, 0, 0);
        chk_cnt++;
        if (overflow8 !== 1'b1) $display("FAIL ovf_second_add: overflow=%0b, required 1", overflow8);
        else pass_cnt++;
        cyc(0, 0, 0, 1, 0);
        chk_cnt++;
        if (soma8 !== exp_acc2) $display("FAIL ovf_acc: soma=%0d, required %0d", soma8, exp_acc2);
        else pass_cnt++;
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk_cnt++;
        if ({soma8, overflow8} !== {exp_acc3, 1'b1})
            $display("FAIL ovf_sticky: soma=%0d overflow=%0b, required soma=%0d overflow=1", soma8, overflow8, exp_acc3);
        else pass_cnt++;
        cyc(1, 0, 0, 0, 8'd3);
        chk_cnt++;
        if (overflow8 !== 1'b0) $display("FAIL ovf_cleared_by_set: overflow=%0b, required 0", overflow8);
        else pass_cnt++;
    endtask

    task automatic test_set_priority;
        cyc(1, 0, 0, 0, 8'd2);
        cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 8'd7);
        cyc(0, 0, 0, 1, 0);
        chk_cnt++;
        if (soma !== 16'd0) $display("FAIL set_priority_acc: soma=%0d, required 0", soma);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
        chk_cnt++;
        if (zero !== 1'b0) $display("FAIL set_priority_cnt6: zero=%0b, required 0", zero);
        else pass_cnt++;
        cyc(0, 1, 0, 0, 0);
        chk_cnt++;
        if (zero !== 1'b1) $display("FAIL set_priority_cnt7: zero=%0b, required 1", zero);
        else pass_cnt++;
    endtask

    task automatic test_dec_cac_at_zero;
        cyc(1, 0, 0, 0, 8'd4);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 0, 0);
            chk_cnt++;
            if (zero !== 1'b1) $display("FAIL zero_hold_step%0d: zero=%0b, required 1", i, zero);
            else pass_cnt++;
        end
        cyc(0, 0, 0, 1, 0);
        chk_cnt++;
        if (soma !== 16'd10) $display("FAIL zero_hold_acc: soma=%0d, required 10", soma);
        else pass_cnt++;
    endtask

    task automatic test_rac_with_cac;
        cyc(1, 0, 0, 0, 8'd5);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        chk_cnt++;
        if (soma !== 16'd9) $display("FAIL rac_cac_soma: soma=%0d, required 9", soma);
        else pass_cnt++;
        cyc(0, 0, 0, 0, 0);
        chk_cnt++;
        if (soma !== 16'd9) $display("FAIL soma_hold: soma=%0d, required 9", soma);
        else pass_cnt++;
        cyc(0, 0, 0, 1, 0);
        chk_cnt++;
        if ({soma, zero} !== {16'd12, 1'b0})
            $display("FAIL rac_cac_acc: soma=%0d zero=%0b, required soma=12 zero=0", soma, zero);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_reset_mid_sum();
        test_nominal_sum();
        test_n_zero();
        test_overflow();
        test_set_priority();
        test_dec_cac_at_zero();
        test_rac_with_cac();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/datapath_somatorio.md
# datapath_somatorio

Datapath for the summation unit: holds a down-counter loaded with N and an accumulator that sums the counter's successive values, N + (N-1) + … + 1. It sits under the summation controller FSM. It executes that FSM's control strobes (set, dec, cac, rac) and returns the status it decides on (zero, overflow). Result is N·(N+1)/2, captured in a stable output register.

## Interface
- WIDTH, 8, width of operand N and the down-counter
- ACC_WIDTH, 16, width of accumulator and result; must be ≥ WIDTH
- ck  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- n_in  input  WIDTH  operand N, sampled only when set=1
- set  input  1  start: load counter, clear accumulator and overflow
- dec  input  1  decrement counter
- cac  input  1  accumulate: acc ← acc + cnt
- rac  input  1  register result: soma ← acc
- zero  output  1  counter equals 0 (combinational from cnt); drives the controller's zero input
- overflow  output  1  sticky accumulator carry-out flag; drives the controller's overflow_entrada input
- soma  output  ACC_WIDTH  result register

## Operation
- Registers: cnt[WIDTH], acc[ACC_WIDTH], ovf (1 bit), soma[ACC_WIDTH].
- reset low (any time, including mid-sum): cnt=0, acc=0, ovf=0, soma=0 immediately. Consequently zero=1 and overflow=0.
- Priority per edge: set overrides dec and cac. rac is independent and may coincide with any strobe.
- set=1: cnt ← n_in, acc ← 0, ovf ← 0. dec and cac in the same cycle are ignored.
- cac=1 (set=0): sum computed at ACC_WIDTH+1 bits as acc + zero-extended cnt, using the pre-edge cnt value.
  - If carry-out is 1: ovf ← 1.
  - acc update then follows the Configuration section.
- dec=1 (set=0):
  - cnt ≠ 0: cnt ← cnt − 1.
  - cnt = 0: cnt holds at 0, with no wrap to all-ones.
- dec and cac together: the add uses the old cnt and the decrement happens on the same edge. This is the normal loop step.
- rac=1: soma ← acc, using the pre-edge acc. If cac is also active, soma gets the value before the add.
- ovf is sticky. It is cleared only by set or reset.
- No strobes asserted: all registers hold.
- No internal FSM. Sequencing is owned by the controller.

## Timing
- All register effects are visible one cycle after the strobe edge.
- zero is combinational from cnt. It is valid in the same cycle cnt changes, with no extra register stage, so the controller can branch on it the next cycle.
- overflow is ovf registered. It goes high on the edge of the overflowing cac.
- soma changes only on a rac edge or on reset.
- Full sum of N takes 1 set cycle, then N cycles of dec+cac, then 1 rac cycle.
- zero is asserted right after the Nth dec+cac edge.
- N=0: zero=1 right after set, and a subsequent rac gives soma=0.

## Configuration
- SATURATE_EN defined: on carry-out, acc ← 2^ACC_WIDTH − 1. Any further cac while ovf=1 keeps acc at all-ones.
- SATURATE_EN undefined: acc ← low ACC_WIDTH bits of the sum (wrap-around).
- ovf behaviour is identical in both builds.

## Test plan
- Reset mid-sum:
  - Stimulus: n_in=5, set, 2× dec+cac, then pull reset low asynchronously between edges.
  - Response: cnt=0, acc=0, soma=0, overflow=0, and zero=1 without waiting for a clock edge.
- Nominal sum:
  - Stimulus: n_in=5, set, then 5× dec+cac, then rac.
  - Response: zero=1 after the 5th edge, soma=15, overflow=0.
- Overflow (WIDTH=8, ACC_WIDTH=8):
  - Stimulus: n_in=255, set, then 2× dec+cac.
  - Response: overflow=1 after the 2nd edge. acc=253 (wrap) or 255 (SATURATE_EN). A later set clears overflow.
- set+cac+dec in the same cycle:
  - Stimulus: n_in=7 with all three strobes asserted.
  - Response: cnt=7, acc=0. The cac and dec are ignored.
- dec+cac at zero:
  - Stimulus: with cnt=0 and acc=10, 3× dec+cac.
  - Response: cnt stays 0, acc stays 10, zero stays 1.
- rac with cac:
  - Stimulus: acc=9, cnt=3, rac and cac in the same cycle.
  - Response: soma=9, acc=12.
